ysyx_22040088_core_sequencer: RTL

Multi-cycle sequencer for the RV64 core, replacing single-cycle implicit timing. It drives fetch, execute, memory and writeback through valid/ready handshakes to the IFU and LSU. It gates the decoder's register-file write enable and the PC update so that each fires exactly once per retired instruction. It also owns halt (ebreak), illegal-instruction and bus-timeout error reporting, plus a retired-instruction counter.

---
 rtl/ysyx_22040088_pkg.sv | 49 ++++
 rtl/ysyx_22040088_core_sequencer_if.sv | 25 ++
 rtl/ysyx_22040088_watchdog.sv | 28 ++
 rtl/ysyx_22040088_core_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ysyx_22040088_pkg.sv
// Shared definitions for the ysyx_22040088 core: sequencer state encoding,
// error-cause codes and RV64 major opcodes reused by the control unit.
package ysyx_22040088_pkg;

  localparam logic [3:0] ST_BOOT       = 4'd0;
  localparam logic [3:0] ST_FETCH_REQ  = 4'd1;
  localparam logic [3:0] ST_FETCH_WAIT = 4'd2;
  localparam logic [3:0] ST_EXEC       = 4'd3;
  localparam logic [3:0] ST_MEM_REQ    = 4'd4;
  localparam logic [3:0] ST_MEM_WAIT   = 4'd5;
  localparam logic [3:0] ST_WB         = 4'd6;
  localparam logic [3:0] ST_HALT       = 4'd7;
  localparam logic [3:0] ST_ERR        = 4'd8;

  typedef enum logic [3:0] {
    StBoot      = ST_BOOT,
    StFetchReq  = ST_FETCH_REQ,
    StFetchWait = ST_FETCH_WAIT,
    StExec      = ST_EXEC,
    StMemReq    = ST_MEM_REQ,
    StMemWait   = ST_MEM_WAIT,
    StWb        = ST_WB,
    StHalt      = ST_HALT,
    StErr       = ST_ERR
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_BUS     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic is_wait_state(seq_state_e st);
    return (st == StFetchWait) || (st == StMemWait);
  endfunction

endpackage

// File: rtl/ysyx_22040088_core_sequencer_if.sv
// IFU and LSU request/response handshake bundle between the sequencer (master)
// and the bus-side units (slave).
interface ysyx_22040088_core_sequencer_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_resp_valid;
  logic ifu_resp_err;
  logic lsu_req_valid;
  logic lsu_req_wen;
  logic lsu_req_ready;
  logic lsu_resp_valid;
  logic lsu_resp_err;

  modport master (
    output ifu_req_valid, lsu_req_valid, lsu_req_wen,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_err
  );

  modport slave (
    input  ifu_req_valid, lsu_req_valid, lsu_req_wen,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_err
  );
endinterface

// File: rtl/ysyx_22040088_watchdog.sv
// Bus-response watchdog: counts waiting cycles and flags the cycle in which the
// count would reach TIMEOUT_CYC without a response.
module ysyx_22040088_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt_q;

  assign expired = enable && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22040088_core_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer: drives IFU/LSU handshakes,
// fires rf_we/pc_we once per retired instruction and reports halt/error.
module ysyx_22040088_core_sequencer
  import ysyx_22040088_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  ysyx_22040088_core_sequencer_if.master        bus,
  output logic                                  inst_we,
  input  logic                                  dec_rf_we,
  input  logic                                  dec_is_load,
  input  logic                                  dec_is_store,
  input  logic                                  dec_halt,
  input  logic                                  dec_illegal,
  output logic                                  rf_we,
  output logic                                  pc_we,
  output logic                                  halted,
  output logic                                  error,
  output logic [1:0]                            err_cause,
  output logic [CNT_W-1:0]                      retired
);

  seq_state_e       state_q;
  logic             rf_we_q;
  logic             is_store_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] retired_q;

  logic in_wait;
  logic wait_resp;
  logic wd_expired;

  assign in_wait   = is_wait_state(state_q);
  assign wait_resp = ((state_q == StFetchWait) && bus.ifu_resp_valid) ||
                     ((state_q == StMemWait)   && bus.lsu_resp_valid);

  // Counter is held at zero outside the wait states, so every entry starts fresh.
  ysyx_22040088_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .enable  (in_wait && !wait_resp),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      rf_we_q    <= 1'b0;
      is_store_q <= 1'b0;
      cause_q    <= ERR_NONE;
      retired_q  <= '0;
    end else begin
      case (state_q)
        StBoot:     state_q <= StFetchReq;
        StFetchReq: if (bus.ifu_req_ready) state_q <= StFetchWait;
        StFetchWait: begin
          if (bus.ifu_resp_valid) begin
            if (bus.ifu_resp_err) begin
              state_q <= StErr;
              cause_q <= ERR_BUS;
            end else begin
              state_q <= StExec;
            end
          end else if (wd_expired) begin
            state_q <= StErr;
            cause_q <= ERR_TIMEOUT;
          end
        end
        StExec: begin
          rf_we_q    <= dec_rf_we;
          is_store_q <= dec_is_store;
          if (dec_illegal) begin
            state_q <= StErr;
            cause_q <= ERR_ILLEGAL;
          end else if (dec_halt) begin
            state_q <= StHalt;
          end else if (dec_is_load || dec_is_store) begin
            state_q <= StMemReq;
          end else begin
            state_q <= StWb;
          end
        end
        StMemReq:   if (bus.lsu_req_ready) state_q <= StMemWait;
        StMemWait: begin
          if (bus.lsu_resp_valid) begin
            if (bus.lsu_resp_err) begin
              state_q <= StErr;
              cause_q <= ERR_BUS;
            end else begin
              state_q <= StWb;
            end
          end else if (wd_expired) begin
            state_q <= StErr;
            cause_q <= ERR_TIMEOUT;
          end
        end
        StWb: begin
          retired_q <= retired_q + 1'b1;
          state_q   <= StFetchReq;
        end
        StHalt, StErr: state_q <= state_q;
        default:       state_q <= StErr;
      endcase
    end
  end

  assign bus.ifu_req_valid = (state_q == StFetchReq);
  assign bus.lsu_req_valid = (state_q == StMemReq);
  assign bus.lsu_req_wen   = (state_q == StMemReq) && is_store_q;
  assign inst_we           = (state_q == StFetchWait) && bus.ifu_resp_valid && !bus.ifu_resp_err;
  assign pc_we             = (state_q == StWb);
  assign rf_we             = (state_q == StWb) && rf_we_q && !is_store_q;
  assign halted            = (state_q == StHalt);
  assign error             = (state_q == StErr);
  assign err_cause         = cause_q;
  assign retired           = retired_q;

endmodule
